// File: rtl/decode_pipe.sv
// RV32I ID stage plus ID/EX register: one instruction per cycle under valid/ready,
// load-use stall, jump/branch redirect that squashes the wrong-path instruction.
module decode_pipe #(
    parameter int unsigned ADDRESS_BITS = 16,
    parameter int unsigned CNT_BITS     = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDRESS_BITS-1:0] PC,
    input  logic [31:0]             instruction,
    input  logic [ADDRESS_BITS-1:0] JALR_target,
    input  logic                    branch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDRESS_BITS-1:0] ex_PC,
    output logic [4:0]              read_sel1,
    output logic [4:0]              read_sel2,
    output logic [4:0]              write_sel,
    output logic                    wEn,
    output logic                    mem_wEn,
    output logic                    mem_rEn,
    output logic                    wb_sel,
    output logic                    branch_op,
    output logic                    op_B_sel,
    output logic [1:0]              op_A_sel,
    output logic [5:0]              ALU_Control,
    output logic [31:0]             imm32,
    output logic                    next_PC_select,
    output logic [ADDRESS_BITS-1:0] target_PC,
    output logic [CNT_BITS-1:0]     stall_count,
    output logic [CNT_BITS-1:0]     flush_count
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic                    valid;
        logic [ADDRESS_BITS-1:0] pc;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [4:0]              rd;
        logic                    wen;
        logic                    mem_wen;
        logic                    mem_ren;
        logic                    wb_sel;
        logic                    branch_op;
        logic                    op_b_sel;
        logic [1:0]              op_a_sel;
        logic [5:0]              alu;
        logic [31:0]             imm;
        logic                    jal;
        logic                    jalr;
    } idex_t;

    idex_t                idex_q, idex_d, dec;
    logic [CNT_BITS-1:0]  stall_q, stall_d, flush_q, flush_d;
    logic                 uses_rs1, uses_rs2;
    logic                 advance, redirect, hazard;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b  = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
    assign imm_j  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};
    assign imm_u  = {instruction[31:12], 12'b0};

    // Opcode decode of the incoming instruction; unknown opcodes become a NOP.
    always_comb begin
        dec          = '0;
        dec.pc       = PC;
        dec.rs1      = instruction[19:15];
        dec.rs2      = instruction[24:20];
        dec.rd       = instruction[11:7];
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        case (opcode)
            OP_R: begin
                dec.wen  = 1'b1;
                dec.alu  = {instruction[30], 2'b00, funct3};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_IMM: begin
                dec.wen      = 1'b1;
                dec.op_b_sel = 1'b1;
                dec.alu      = {(funct3 == 3'b101) ? instruction[30] : 1'b0, 2'b00, funct3};
                dec.imm      = imm_i;
                uses_rs1     = 1'b1;
            end
            OP_LOAD: begin
                dec.wen      = 1'b1;
                dec.mem_ren  = 1'b1;
                dec.wb_sel   = 1'b1;
                dec.op_b_sel = 1'b1;
                dec.imm      = imm_i;
                uses_rs1     = 1'b1;
            end
            OP_STORE: begin
                dec.mem_wen  = 1'b1;
                dec.op_b_sel = 1'b1;
                dec.imm      = imm_s;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch_op = 1'b1;
                dec.alu       = {3'b010, funct3};
                dec.imm       = imm_b;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_JAL: begin
                dec.wen      = 1'b1;
                dec.op_a_sel = 2'b10;
                dec.alu      = 6'b011111;
                dec.imm      = imm_j;
                dec.jal      = 1'b1;
            end
            OP_JALR: begin
                dec.wen      = 1'b1;
                dec.op_a_sel = 2'b10;
                dec.alu      = 6'b011111;
                dec.imm      = imm_i;
                dec.jalr     = 1'b1;
                uses_rs1     = 1'b1;
            end
            OP_LUI: begin
                dec.wen      = 1'b1;
                dec.op_a_sel = 2'b11;
                dec.op_b_sel = 1'b1;
                dec.imm      = imm_u;
            end
            OP_AUIPC: begin
                dec.wen      = 1'b1;
                dec.op_a_sel = 2'b01;
                dec.op_b_sel = 1'b1;
                dec.imm      = imm_u;
            end
            default: ;
        endcase
    end

    assign advance  = out_ready | ~idex_q.valid;
    assign redirect = idex_q.valid & (idex_q.jal | idex_q.jalr | (idex_q.branch_op & branch));
    assign hazard   = idex_q.valid & idex_q.mem_ren & (idex_q.rd != 5'd0) & in_valid &
                      ((uses_rs1 & (dec.rs1 == idex_q.rd)) | (uses_rs2 & (dec.rs2 == idex_q.rd)));
    assign in_ready = advance & (~hazard | redirect);

    // A redirect wins over a stall: the pending instruction is on the wrong path anyway.
    always_comb begin
        idex_d  = idex_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (advance) begin
            if (redirect) begin
                idex_d = '0;
                if (flush_q != CNT_MAX) flush_d = flush_q + CNT_BITS'(1);
            end else if (hazard) begin
                idex_d = '0;
                if (stall_q != CNT_MAX) stall_d = stall_q + CNT_BITS'(1);
            end else begin
                idex_d       = dec;
                idex_d.valid = in_valid;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            idex_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            idex_q  <= idex_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign out_valid      = idex_q.valid;
    assign ex_PC          = idex_q.pc;
    assign read_sel1      = idex_q.rs1;
    assign read_sel2      = idex_q.rs2;
    assign write_sel      = idex_q.rd;
    assign wEn            = idex_q.wen;
    assign mem_wEn        = idex_q.mem_wen;
    assign mem_rEn        = idex_q.mem_ren;
    assign wb_sel         = idex_q.wb_sel;
    assign branch_op      = idex_q.branch_op;
    assign op_B_sel       = idex_q.op_b_sel;
    assign op_A_sel       = idex_q.op_a_sel;
    assign ALU_Control    = idex_q.alu;
    assign imm32          = idex_q.imm;
    assign next_PC_select = redirect;
    assign target_PC      = idex_q.jalr ? (JALR_target & ~ADDRESS_BITS'(1))
                                        : (idex_q.pc + idex_q.imm[ADDRESS_BITS-1:0]);
    assign stall_count    = stall_q;
    assign flush_count    = flush_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: decode table plus stall, flush, backpressure,
// reset and counter-saturation sequences.
module tb_decode_pipe;
    localparam int unsigned AW = 16;
    localparam int unsigned CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] PC;
    logic [31:0]   instruction;
    logic [AW-1:0] JALR_target;
    logic          branch;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] ex_PC;
    logic [4:0]    read_sel1, read_sel2, write_sel;
    logic          wEn, mem_wEn, mem_rEn, wb_sel, branch_op, op_B_sel;
    logic [1:0]    op_A_sel;
    logic [5:0]    ALU_Control;
    logic [31:0]   imm32;
    logic          next_PC_select;
    logic [AW-1:0] target_PC;
    logic [CW-1:0] stall_count, flush_count;
    logic [7:0]    ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    decode_pipe #(.ADDRESS_BITS(AW), .CNT_BITS(CW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .PC(PC), .instruction(instruction), .JALR_target(JALR_target), .branch(branch),
        .out_valid(out_valid), .out_ready(out_ready), .ex_PC(ex_PC),
        .read_sel1(read_sel1), .read_sel2(read_sel2), .write_sel(write_sel),
        .wEn(wEn), .mem_wEn(mem_wEn), .mem_rEn(mem_rEn), .wb_sel(wb_sel),
        .branch_op(branch_op), .op_B_sel(op_B_sel), .op_A_sel(op_A_sel),
        .ALU_Control(ALU_Control), .imm32(imm32), .next_PC_select(next_PC_select),
        .target_PC(target_PC), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    assign ctrl = {wEn, mem_wEn, mem_rEn, wb_sel, branch_op, op_B_sel, op_A_sel};

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [7:0]  ctrl;   // {wEn,mem_wEn,mem_rEn,wb_sel,branch_op,op_B_sel,op_A_sel}
        logic [5:0]  alu;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{32'hFFF00593, 5'd11, 5'd0,  5'd31, 8'b1000_0100, 6'b000000, 32'hFFFFFFFF}; // addi a1,zero,-1
        vecs[1]  = '{32'h0005A903, 5'd18, 5'd11, 5'd0,  8'b1011_0100, 6'b000000, 32'h00000000}; // lw s2,0(a1)
        vecs[2]  = '{32'h00C90833, 5'd16, 5'd18, 5'd12, 8'b1000_0000, 6'b000000, 32'h00000000}; // add a6,s2,a2
        vecs[3]  = '{32'h40E608B3, 5'd17, 5'd12, 5'd14, 8'b1000_0000, 6'b100000, 32'h00000000}; // sub a7,a2,a4
        vecs[4]  = '{32'h40335293, 5'd5,  5'd6,  5'd3,  8'b1000_0100, 6'b100101, 32'h00000403}; // srai x5,x6,3
        vecs[5]  = '{32'h40017093, 5'd1,  5'd2,  5'd0,  8'b1000_0100, 6'b000111, 32'h00000400}; // andi x1,x2,0x400
        vecs[6]  = '{32'hFE512E23, 5'd28, 5'd2,  5'd5,  8'b0100_0100, 6'b000000, 32'hFFFFFFFC}; // sw x5,-4(x2)
        vecs[7]  = '{32'h00208863, 5'd16, 5'd1,  5'd2,  8'b0000_1000, 6'b010000, 32'h00000010}; // beq x1,x2,16
        vecs[8]  = '{32'hFE419CE3, 5'd25, 5'd3,  5'd4,  8'b0000_1000, 6'b010001, 32'hFFFFFFF8}; // bne x3,x4,-8
        vecs[9]  = '{32'hDEADB1B7, 5'd3,  5'd27, 5'd10, 8'b1000_0111, 6'b000000, 32'hDEADB000}; // lui
        vecs[10] = '{32'hDEADB197, 5'd3,  5'd27, 5'd10, 8'b1000_0101, 6'b000000, 32'hDEADB000}; // auipc
        vecs[11] = '{32'hFFFFFFFF, 5'd31, 5'd31, 5'd31, 8'b0000_0000, 6'b000000, 32'h00000000}; // unknown opcode

        reset = 1'b0; in_valid = 1'b1; instruction = 32'hFFF00593; PC = 16'h0010;
        JALR_target = '0; branch = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_write_sel", 32'(write_sel), 32'd0);
        chk("rst_ctrl", 32'(ctrl), 32'd0);
        chk("rst_imm32", imm32, 32'd0);
        chk("rst_nps", 32'(next_PC_select), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        chk("rst_flush", 32'(flush_count), 32'd0);
        reset = 1'b1;

        // Decode table: each vector is followed by an idle cycle so no hazard or redirect arises.
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; instruction = vecs[i].inst; PC = AW'(32'h0100 + 4 * i);
            tick();
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_ex_PC", i), 32'(ex_PC), 32'h0100 + 32'(4 * i));
            chk($sformatf("v%0d_write_sel", i), 32'(write_sel), 32'(vecs[i].rd));
            chk($sformatf("v%0d_read_sel1", i), 32'(read_sel1), 32'(vecs[i].rs1));
            chk($sformatf("v%0d_read_sel2", i), 32'(read_sel2), 32'(vecs[i].rs2));
            chk($sformatf("v%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].ctrl));
            chk($sformatf("v%0d_alu", i), 32'(ALU_Control), 32'(vecs[i].alu));
            chk($sformatf("v%0d_imm32", i), imm32, vecs[i].imm);
            chk($sformatf("v%0d_nps", i), 32'(next_PC_select), 32'd0);
            in_valid = 1'b0;
            tick();
        end
        chk("tbl_stall", 32'(stall_count), 32'd0);
        chk("tbl_flush", 32'(flush_count), 32'd0);

        // Load-use: lw s2 then add using s2.
        in_valid = 1'b1; PC = 16'h0040; instruction = 32'h0005A903;
        tick();
        PC = 16'h0044; instruction = 32'h00C90833; #1;
        chk("lu_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("lu_bubble", 32'(out_valid), 32'd0);
        chk("lu_stall", 32'(stall_count), 32'd1);
        chk("lu_in_ready_after", 32'(in_ready), 32'd1);
        tick();
        chk("lu_add_valid", 32'(out_valid), 32'd1);
        chk("lu_add_rs1", 32'(read_sel1), 32'd18);
        chk("lu_add_rd", 32'(write_sel), 32'd16);
        chk("lu_add_pc", 32'(ex_PC), 32'h0044);
        in_valid = 1'b0;
        tick();

        // Load into x0 never stalls a consumer of x0.
        in_valid = 1'b1; PC = 16'h0050; instruction = 32'h0005A003;
        tick();
        PC = 16'h0054; instruction = 32'h00C00833; #1;
        chk("x0_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("x0_add_valid", 32'(out_valid), 32'd1);
        chk("x0_stall", 32'(stall_count), 32'd1);
        in_valid = 1'b0;
        tick();

        // jal zero,0x14 at 0x0114 squashes the next instruction.
        in_valid = 1'b1; PC = 16'h0114; instruction = 32'h0140006F;
        tick();
        PC = 16'h0118; instruction = 32'hFFF00593; #1;
        chk("jal_nps", 32'(next_PC_select), 32'd1);
        chk("jal_target", 32'(target_PC), 32'h0128);
        chk("jal_in_ready", 32'(in_ready), 32'd1);
        chk("jal_op_a", 32'(op_A_sel), 32'd2);
        chk("jal_alu", 32'(ALU_Control), 32'h1F);
        chk("jal_imm", imm32, 32'h14);
        tick();
        chk("jal_bubble", 32'(out_valid), 32'd0);
        chk("jal_flush", 32'(flush_count), 32'd1);
        chk("jal_nps_after", 32'(next_PC_select), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("jal_dropped", 32'(out_valid), 32'd0);

        // jalr ra,0(a0) with JALR_target 0x0155.
        in_valid = 1'b1; PC = 16'h0200; instruction = 32'h000500E7;
        tick();
        in_valid = 1'b0; JALR_target = 16'h0155; #1;
        chk("jalr_nps", 32'(next_PC_select), 32'd1);
        chk("jalr_target", 32'(target_PC), 32'h0154);
        tick();
        chk("jalr_flush", 32'(flush_count), 32'd2);

        // beq at 0x0008, first not taken then taken.
        in_valid = 1'b1; PC = 16'h0008; instruction = 32'h00208863; branch = 1'b0;
        tick();
        in_valid = 1'b0; #1;
        chk("beq_nt_nps", 32'(next_PC_select), 32'd0);
        branch = 1'b1; #1;
        chk("beq_t_nps", 32'(next_PC_select), 32'd1);
        chk("beq_t_target", 32'(target_PC), 32'h0018);
        tick();
        branch = 1'b0;
        chk("beq_flush", 32'(flush_count), 32'd3);
        chk("beq_bubble", 32'(out_valid), 32'd0);

        // Backpressure holds a registered sub for 3 cycles.
        in_valid = 1'b1; PC = 16'h0300; instruction = 32'h40E608B3;
        tick();
        out_ready = 1'b0; PC = 16'h0304; instruction = 32'hFFF00593;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_rd", c), 32'(write_sel), 32'd17);
            chk($sformatf("bp%0d_alu", c), 32'(ALU_Control), 32'h20);
            chk($sformatf("bp%0d_pc", c), 32'(ex_PC), 32'h0300);
            chk($sformatf("bp%0d_cnt", c), 32'({stall_count, flush_count}), 32'h13);
            if (c < 3) tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_next_rd", 32'(write_sel), 32'd11);
        chk("bp_next_pc", 32'(ex_PC), 32'h0304);
        in_valid = 1'b0;
        tick();

        // Redirect stays asserted while execute stalls, flush counted once on accept.
        in_valid = 1'b1; PC = 16'h0400; instruction = 32'h0140006F;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rh_nps", 32'(next_PC_select), 32'd1);
        chk("rh_target", 32'(target_PC), 32'h0414);
        chk("rh_flush_held", 32'(flush_count), 32'd3);
        out_ready = 1'b1;
        tick();
        chk("rh_flush", 32'(flush_count), 32'd4);
        chk("rh_bubble", 32'(out_valid), 32'd0);

        // Reset during a load-use stall clears everything.
        in_valid = 1'b1; PC = 16'h0500; instruction = 32'h0005A903;
        tick();
        instruction = 32'h00C90833; reset = 1'b0;
        tick();
        chk("rs_valid", 32'(out_valid), 32'd0);
        chk("rs_mem_ren", 32'(mem_rEn), 32'd0);
        chk("rs_rd", 32'(write_sel), 32'd0);
        chk("rs_counts", 32'({stall_count, flush_count}), 32'd0);
        chk("rs_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1; in_valid = 1'b0;
        tick();

        // Stall counter saturates at all-ones.
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1; instruction = 32'h0005A903;
            tick();
            instruction = 32'h00C90833;
            tick();
            tick();
            if (k == 13) chk("sat_stall_14", 32'(stall_count), 32'd14);
        end
        in_valid = 1'b0;
        tick();
        chk("sat_stall", 32'(stall_count), 32'd15);

        // Flush counter saturates at all-ones.
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1; instruction = 32'h0140006F;
            tick();
            in_valid = 1'b0;
            tick();
        end
        chk("sat_flush", 32'(flush_count), 32'd15);
        chk("sat_stall_kept", 32'(stall_count), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
